idma_axi_read_responder: RTL and testbench

AXI4 read subordinate that serves the INCR AR bursts emitted by the iDMA legalizer. It sits between an iDMA read backend and a single-port SRAM with fixed 1-cycle read latency. Each accepted burst becomes len+1 word reads. The block returns R beats in order with correct RLAST and RRESP under full R backpressure. It is the test/TCDM-side counterpart used to close the read path in iDMA benches and simple SoCs.

---
 rtl/idma_axi_resp_pkg.sv | 24 ++
 rtl/fifo_v3.sv | 84 ++++++++
 rtl/idma_axi_read_responder.sv | 153 +++++++++++++++
 tb/tb_idma_axi_read_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_axi_resp_pkg.sv
// Shared types and constants for the iDMA AXI read responder.
// Beat fields are sized by the package widths; the top casts its ports onto them.
package idma_axi_resp_pkg;

   localparam int unsigned RspIdWidth   = 4;
   localparam int unsigned RspDataWidth = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BurstIncr   = 2'b01;

   typedef enum logic {
      IDLE,
      BURST
   } state_e;

   typedef struct packed {
      logic [RspIdWidth-1:0]   id;
      logic [RspDataWidth-1:0] data;
      logic [1:0]              resp;
      logic                    last;
   } rsp_beat_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic FIFO compatible with the common_cells fifo_v3 interface.
// With FALL_THROUGH set, a push into an empty FIFO is visible on data_o in the same cycle.
module fifo_v3 #(
   parameter bit           FALL_THROUGH = 1'b0,
   parameter int unsigned  DEPTH        = 8,
   parameter type          dtype        = logic [31:0],
   localparam int unsigned AddrDepth    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [AddrDepth-1:0] usage_o,
   input  dtype                 data_i,
   input  logic                 push_i,
   output dtype                 data_o,
   input  logic                 pop_i
);

   localparam logic [AddrDepth:0]   FullCnt = (AddrDepth + 1)'(DEPTH);
   localparam logic [AddrDepth-1:0] LastPtr = AddrDepth'(DEPTH - 1);

   logic [AddrDepth-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrDepth-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrDepth:0]   cnt_q, cnt_d;
   logic                 do_push, do_pop, bypass, write_en;
   dtype                 mem_q [DEPTH];

   assign full_o   = (cnt_q == FullCnt);
   assign empty_o  = (cnt_q == '0) && !(FALL_THROUGH && push_i);
   assign usage_o  = cnt_q[AddrDepth-1:0];
   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;
   // A push popped in the same cycle from an empty FIFO never touches storage.
   assign bypass   = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
   assign write_en = do_push && !bypass && !flush_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      data_o   = mem_q[rd_ptr_q];
      if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
         data_o = data_i;
      end
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else if (!bypass) begin
         if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (write_en) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/idma_axi_read_responder.sv
// AXI4 read subordinate turning INCR AR bursts into single-word SRAM reads.
// Unsupported bursts are answered with SLVERR beats without touching the SRAM.
module idma_axi_read_responder import idma_axi_resp_pkg::*; #(
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned MemAddrWidth = 16,
   parameter int unsigned RspDepth     = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [IdWidth-1:0]      ar_id_i,
   input  logic [AddrWidth-1:0]    ar_addr_i,
   input  logic [7:0]              ar_len_i,
   input  logic [2:0]              ar_size_i,
   input  logic [1:0]              ar_burst_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   output logic [IdWidth-1:0]      r_id_o,
   output logic [DataWidth-1:0]    r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_last_o,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic                    mem_req_o,
   output logic [MemAddrWidth-1:0] mem_addr_o,
   input  logic [DataWidth-1:0]    mem_rdata_i
);

   localparam int unsigned OffsetBits = $clog2(DataWidth / 8);
   localparam logic [2:0]  BeatSize   = 3'(OffsetBits);
   localparam int unsigned UsageWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned CntWidth   = $clog2(RspDepth + 2);

   state_e                  state_q, state_d;
   logic [IdWidth-1:0]      id_q, pend_id_q;
   logic [7:0]              len_q, cnt_q;
   logic [MemAddrWidth-1:0] addr_q;
   logic                    err_q, in_flight_q, pend_last_q;
   logic                    issue, last_beat, credit_ok;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop, rst_n;
   logic [UsageWidth-1:0]   fifo_usage;
   logic [CntWidth-1:0]     fifo_cnt;
   rsp_beat_t               push_beat, pop_beat;
   logic                    unused_addr;

   assign unused_addr = ^ar_addr_i;
   assign rst_n       = ~rst_i;
   assign last_beat   = (cnt_q == len_q);
   assign mem_addr_o  = addr_q;

   // The outstanding SRAM read reserves a FIFO slot so its data always has room.
   assign fifo_cnt  = fifo_full ? CntWidth'(RspDepth) : CntWidth'(fifo_usage);
   assign credit_ok = (fifo_cnt + CntWidth'(in_flight_q)) < CntWidth'(RspDepth);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ar_valid_i) state_d = BURST;
         BURST:   if (issue && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ar_ready_o = 1'b0;
      issue      = 1'b0;
      unique case (state_q)
         IDLE:    ar_ready_o = 1'b1;
         BURST:   issue      = credit_ok;
         default: ar_ready_o = 1'b0;
      endcase
      mem_req_o = issue && !err_q;
   end

   // Returning data carries the id/last captured at issue, since a new AR may already be latched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_q        <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         in_flight_q <= 1'b0;
         pend_id_q   <= '0;
         pend_last_q <= 1'b0;
      end else begin
         in_flight_q <= mem_req_o;
         if (mem_req_o) begin
            pend_id_q   <= id_q;
            pend_last_q <= last_beat;
         end
         if (ar_ready_o && ar_valid_i) begin
            id_q   <= ar_id_i;
            len_q  <= ar_len_i;
            cnt_q  <= '0;
            addr_q <= MemAddrWidth'(ar_addr_i >> OffsetBits);
            err_q  <= (ar_burst_i != BurstIncr) || (ar_size_i != BeatSize);
         end else if (issue) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_q + 1'b1;
         end
      end
   end

   always_comb begin
      fifo_push = in_flight_q || (issue && err_q);
      if (in_flight_q) begin
         push_beat.id   = RspIdWidth'(pend_id_q);
         push_beat.data = RspDataWidth'(mem_rdata_i);
         push_beat.resp = RESP_OKAY;
         push_beat.last = pend_last_q;
      end else begin
         push_beat.id   = RspIdWidth'(id_q);
         push_beat.data = '0;
         push_beat.resp = RESP_SLVERR;
         push_beat.last = last_beat;
      end
   end

   assign r_valid_o = !fifo_empty;
   assign fifo_pop  = r_valid_o && r_ready_i;
   assign r_id_o    = IdWidth'(pop_beat.id);
   assign r_data_o  = DataWidth'(pop_beat.data);
   assign r_resp_o  = pop_beat.resp;
   assign r_last_o  = pop_beat.last;

   fifo_v3 #(
      .FALL_THROUGH (1'b1),
      .DEPTH        (RspDepth),
      .dtype        (rsp_beat_t)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_n),
      .flush_i (1'b0),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (fifo_usage),
      .data_i  (push_beat),
      .push_i  (fifo_push),
      .data_o  (pop_beat),
      .pop_i   (fifo_pop)
   );

endmodule

// File: tb/tb_idma_axi_read_responder.sv
// Self-checking bench for idma_axi_read_responder: table-driven bursts plus
// hand-written backpressure, back-to-back and mid-burst reset sequences.
module tb_idma_axi_read_responder;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  ar_id_i = '0;
   logic [31:0] ar_addr_i = '0;
   logic [7:0]  ar_len_i = '0;
   logic [2:0]  ar_size_i = '0;
   logic [1:0]  ar_burst_i = '0;
   logic        ar_valid_i = 1'b0;
   logic        ar_ready_o;
   logic [3:0]  r_id_o;
   logic [31:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        r_last_o;
   logic        r_valid_o;
   logic        r_ready_i = 1'b0;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic [31:0] mem_rdata_i = '0;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   logic [38:0] beatQ[$];
   int          beatCycQ[$];
   logic [15:0] issueQ[$];
   int          issueCycQ[$];

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [15:0] expWord;
      logic        expErr;
   } vec_t;

   vec_t vecs[6];

   idma_axi_read_responder dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ar_id_i     (ar_id_i),
      .ar_addr_i   (ar_addr_i),
      .ar_len_i    (ar_len_i),
      .ar_size_i   (ar_size_i),
      .ar_burst_i  (ar_burst_i),
      .ar_valid_i  (ar_valid_i),
      .ar_ready_o  (ar_ready_o),
      .r_id_o      (r_id_o),
      .r_data_o    (r_data_o),
      .r_resp_o    (r_resp_o),
      .r_last_o    (r_last_o),
      .r_valid_o   (r_valid_o),
      .r_ready_i   (r_ready_i),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] memFn(input logic [15:0] a);
      return {~a, a};
   endfunction

   function automatic logic [38:0] expBeat(input logic [3:0] id, input logic [31:0] data,
                                           input logic [1:0] resp, input logic last);
      return {id, data, resp, last};
   endfunction

   // SRAM model with a fixed one-cycle read latency
   always @(posedge clk_i) begin
      if (mem_req_o) mem_rdata_i <= memFn(mem_addr_o);
   end

   // Handshakes are recorded mid-cycle, tagged with the cycle they complete in
   always @(negedge clk_i) begin
      if (!rst_i && r_valid_o && r_ready_i) begin
         beatQ.push_back({r_id_o, r_data_o, r_resp_o, r_last_o});
         beatCycQ.push_back(cyc);
      end
      if (!rst_i && mem_req_o) begin
         issueQ.push_back(mem_addr_o);
         issueCycQ.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearQueues();
      beatQ.delete();
      beatCycQ.delete();
      issueQ.delete();
      issueCycQ.delete();
   endtask

   task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, output int hsCyc);
      ar_id_i    = id;
      ar_addr_i  = addr;
      ar_len_i   = len;
      ar_size_i  = size;
      ar_burst_i = burst;
      ar_valid_i = 1'b1;
      for (int k = 0; k < 300 && !ar_ready_o; k++) tick();
      if (!ar_ready_o) begin
         checkOutput("arAccept", 64'(ar_ready_o), 64'd1);
         hsCyc = -1;
      end else begin
         hsCyc = cyc;
      end
      tick();
      ar_valid_i = 1'b0;
   endtask

   task automatic waitBeats(input int n, input int budget);
      for (int k = 0; k < budget && beatQ.size() < n; k++) tick();
   endtask

   task automatic checkBurst(input string tag, input vec_t v, input int hsCyc);
      int n;
      logic [15:0] a;
      n = int'(v.len) + 1;
      waitBeats(n, n + 40);
      repeat (4) tick();
      checkOutput({tag, " beatCount"}, 64'(beatQ.size()), 64'(n));
      for (int i = 0; i < n && i < beatQ.size(); i++) begin
         a = v.expWord + 16'(i);
         checkOutput($sformatf("%s beat%0d", tag, i), 64'(beatQ[i]),
                     64'(expBeat(v.id, v.expErr ? 32'h0 : memFn(a), v.expErr ? 2'b10 : 2'b00, i == n - 1)));
      end
      checkOutput({tag, " issueCount"}, 64'(issueQ.size()), v.expErr ? 64'd0 : 64'(n));
      for (int i = 0; i < issueQ.size() && !v.expErr; i++) begin
         a = v.expWord + 16'(i);
         checkOutput($sformatf("%s issueAddr%0d", tag, i), 64'(issueQ[i]), 64'(a));
      end
      if (beatQ.size() == n) begin
         checkOutput({tag, " firstBeatLatency"}, 64'(beatCycQ[0] - hsCyc), v.expErr ? 64'd1 : 64'd2);
         checkOutput({tag, " beatSpan"}, 64'(beatCycQ[n-1] - beatCycQ[0]), 64'(v.len));
      end
      if (!v.expErr && issueQ.size() > 0) begin
         checkOutput({tag, " issueLatency"}, 64'(issueCycQ[0] - hsCyc), 64'd1);
      end
   endtask

   initial begin
      int hsA, hsB;
      vec_t v;

      vecs[0] = '{id: 4'd3, addr: 32'h40,    len: 8'd0,   size: 3'd2, burst: 2'b01, expWord: 16'h0010, expErr: 1'b0};
      vecs[1] = '{id: 4'd5, addr: 32'h100,   len: 8'd7,   size: 3'd2, burst: 2'b01, expWord: 16'h0040, expErr: 1'b0};
      vecs[2] = '{id: 4'd7, addr: 32'h0,     len: 8'd2,   size: 3'd2, burst: 2'b00, expWord: 16'h0000, expErr: 1'b1};
      vecs[3] = '{id: 4'd1, addr: 32'h3FFF8, len: 8'd3,   size: 3'd2, burst: 2'b01, expWord: 16'hFFFE, expErr: 1'b0};
      vecs[4] = '{id: 4'd2, addr: 32'h8,     len: 8'd1,   size: 3'd3, burst: 2'b01, expWord: 16'h0002, expErr: 1'b1};
      vecs[5] = '{id: 4'd9, addr: 32'h200,   len: 8'd255, size: 3'd2, burst: 2'b01, expWord: 16'h0080, expErr: 1'b0};

      repeat (3) tick();
      checkOutput("resetArReady", 64'(ar_ready_o), 64'd1);
      checkOutput("resetRValid", 64'(r_valid_o), 64'd0);
      checkOutput("resetMemReq", 64'(mem_req_o), 64'd0);
      rst_i = 1'b0;
      r_ready_i = 1'b1;
      tick();

      for (int t = 0; t < 6; t++) begin
         clearQueues();
         applyStimulus(vecs[t].id, vecs[t].addr, vecs[t].len, vecs[t].size, vecs[t].burst, hsA);
         checkBurst($sformatf("vec%0d", t), vecs[t], hsA);
      end

      // Backpressure: ready low for five cycles once the first beat shows up
      r_ready_i = 1'b0;
      clearQueues();
      applyStimulus(4'd6, 32'h20, 8'd3, 3'd2, 2'b01, hsA);
      for (int k = 0; k < 20 && !r_valid_o; k++) tick();
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("bpValid%0d", k), 64'(r_valid_o), 64'd1);
         checkOutput($sformatf("bpStable%0d", k), 64'({r_id_o, r_data_o, r_resp_o, r_last_o}),
                     64'(expBeat(4'd6, memFn(16'h0008), 2'b00, 1'b0)));
         tick();
      end
      checkOutput("bpIssuesWhileStalled", 64'(issueQ.size()), 64'd2);
      r_ready_i = 1'b1;
      waitBeats(4, 40);
      repeat (4) tick();
      checkOutput("bpBeatCount", 64'(beatQ.size()), 64'd4);
      for (int i = 0; i < 4 && i < beatQ.size(); i++) begin
         checkOutput($sformatf("bpBeat%0d", i), 64'(beatQ[i]),
                     64'(expBeat(4'd6, memFn(16'h0008 + 16'(i)), 2'b00, i == 3)));
      end
      checkOutput("bpIssueCount", 64'(issueQ.size()), 64'd4);

      // Back-to-back: B is presented right after A and accepted after A's last issue
      clearQueues();
      applyStimulus(4'd1, 32'h400, 8'd1, 3'd2, 2'b01, hsA);
      applyStimulus(4'd2, 32'h800, 8'd0, 3'd2, 2'b01, hsB);
      checkOutput("b2bAcceptGap", 64'(hsB - hsA), 64'd3);
      waitBeats(3, 40);
      repeat (4) tick();
      checkOutput("b2bBeatCount", 64'(beatQ.size()), 64'd3);
      if (beatQ.size() == 3) begin
         checkOutput("b2bA0", 64'(beatQ[0]), 64'(expBeat(4'd1, memFn(16'h0100), 2'b00, 1'b0)));
         checkOutput("b2bA1", 64'(beatQ[1]), 64'(expBeat(4'd1, memFn(16'h0101), 2'b00, 1'b1)));
         checkOutput("b2bB0", 64'(beatQ[2]), 64'(expBeat(4'd2, memFn(16'h0200), 2'b00, 1'b1)));
      end

      // Reset during beat 2 of an 8-beat burst, then a fresh burst
      clearQueues();
      applyStimulus(4'd4, 32'h0, 8'd7, 3'd2, 2'b01, hsA);
      waitBeats(2, 40);
      rst_i = 1'b1;
      #1;
      checkOutput("midResetRValid", 64'(r_valid_o), 64'd0);
      checkOutput("midResetArReady", 64'(ar_ready_o), 64'd1);
      checkOutput("midResetMemReq", 64'(mem_req_o), 64'd0);
      tick();
      tick();
      clearQueues();
      rst_i = 1'b0;
      repeat (10) tick();
      checkOutput("postResetBeats", 64'(beatQ.size()), 64'd0);
      checkOutput("postResetIssues", 64'(issueQ.size()), 64'd0);
      clearQueues();
      v = '{id: 4'd6, addr: 32'h10, len: 8'd1, size: 3'd2, burst: 2'b01, expWord: 16'h0004, expErr: 1'b0};
      applyStimulus(v.id, v.addr, v.len, v.size, v.burst, hsA);
      checkBurst("afterReset", v, hsA);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
